cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Initiator-side FSM that drives the 4-way set-associative cache storage array.
- Accepts single-word CPU read/write requests and performs tag compare and hit/miss resolution.
- Policy: write-back, write-allocate. Replacement uses NRU ref bits; dirty victims are written back to main memory.
- Sits between the CPU load/store port and the main-memory request/ack port; owns every array write and ref update.

Parameters:
- DATA_WIDTH, 32, word/line width.
- ADDR_WIDTH, 16, byte address width.
- INDEX_WIDTH, 6, set index bits = addr[7:2].
- TAG_WIDTH, 8, tag bits = addr[15:8].
- NUM_WAYS, 4, associativity.
- COUNT_WIDTH, 16, hit/miss counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request valid; sampled only when cpu_ready=1.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_WIDTH  byte address; addr[1:0] ignored.
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_ready  out  1  controller idle, can accept.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_rdata  out  DATA_WIDTH  read data; 0 when cpu_resp_valid=0.
- index  out  INDEX_WIDTH  array set select.
- r_tags  in  NUM_WAYS*TAG_WIDTH  array tags, way i at [i*TAG_WIDTH +: TAG_WIDTH].
- r_data  in  NUM_WAYS*DATA_WIDTH  array data.
- r_valid / r_dirty / r_ref  in  NUM_WAYS each  array state bits.
- wr_en  out  1  array line write.
- way_sel  out  NUM_WAYS  one-hot write way.
- w_tag  out  TAG_WIDTH  tag to write.
- w_data  out  DATA_WIDTH  data to write.
- w_valid, w_dirty  out  1 each  line state to write.
- update_ref  out  1  ref write strobe.
- w_ref  out  NUM_WAYS  new ref vector.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1=writeback, 0=fetch.
- mem_addr  out  ADDR_WIDTH  line address, [1:0]=0.
- mem_wdata  out  DATA_WIDTH  writeback data.
- mem_ack  in  1  one-cycle completion; ignored when mem_req=0.
- mem_rdata  in  DATA_WIDTH  fetch data, valid with mem_ack.
- hit_count, miss_count  out  COUNT_WIDTH  saturating statistics.

Behaviour:
- Array contract: combinational read of the set selected by index; write and ref update land on the next clk edge.
- Reset: state IDLE.
  - cpu_ready=1.
  - All other outputs 0.
  - Counters 0; latched request 0; refill flag 0.
  - Reset mid-transaction aborts immediately: mem_req drops asynchronously and no array write occurs.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE:
  - cpu_ready=1.
  - On cpu_req, latch addr/we/wdata, clear refill flag, go to COMPARE.
- COMPARE:
  - index = latched addr[7:2].
  - hit_way = valid & tag match. At most one way hits; if multiple hit, the lowest way wins.
  - Read hit: cpu_resp_valid=1, cpu_rdata = hit-way data, then IDLE.
  - Write hit: wr_en=1, way_sel=hit, tag unchanged, w_data=latched wdata, w_valid=1, w_dirty=1, cpu_resp_valid=1, then IDLE.
  - Any hit: update_ref=1, w_ref = r_ref | hit_onehot. If that result is all ones, w_ref = hit_onehot.
  - Miss: latch victim way, tag, dirty and data.
    - Victim = lowest invalid way; else lowest way with ref=0; else way 0.
    - Victim valid & dirty goes to WRITEBACK; otherwise ALLOCATE.
  - Latency: request accepted at edge N; read-hit response during cycle N+1.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_wdata = victim data.
  - Outputs stable until mem_ack, then ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_we=0, mem_addr={latched tag, index, 2'b00}.
  - On mem_ack: wr_en=1 on victim way, w_tag = latched tag, w_data = mem_rdata, w_valid=1, w_dirty=0.
  - Set refill flag, go to COMPARE. The re-compare hits and completes the read or write; no ref update during ALLOCATE.
- Counters:
  - Increment only on a COMPARE with refill flag=0: hit_count on hit, miss_count on miss.
  - Saturate at all ones; no wrap.
- cpu_req while cpu_ready=0 is ignored; the CPU must hold the request.

Decomposition:
- cache_pkg: width constants, state enum, field-slice functions (tag_of, index_of, line_addr).
- Sub-module cache_victim_select (combinational): inputs r_valid/r_ref/hit vector; outputs victim one-hot and next ref vector.
- The FSM, latches and counters stay in cache_controller.

Test Plan:
- Cold read 0x1234 → miss_count=1.
  - Expect mem fetch at mem_addr=0x1234. Ack with 0xDEADBEEF.
  - Next cycle cpu_resp_valid=1, cpu_rdata=0xDEADBEEF; hit_count stays 0.
- Repeat read 0x1234 → cpu_resp_valid in cycle after acceptance; no mem_req; hit_count=1.
- Eviction sequence:
  - After reset: write 0x1234←0xA5A5A5A5, then read 0x2234, 0x3234, 0x4234. Refs go 0001, 0011, 0111, then 1000.
  - Read 0x5234 → victim way0 → writeback with mem_we=1, mem_addr=0x1234, mem_wdata=0xA5A5A5A5.
  - Fetch of 0x5234 follows.
- Stall: hold mem_ack low 5 cycles in ALLOCATE → mem_req/mem_addr stable, cpu_ready=0, a pulsed cpu_req is dropped.
- Reset asserted mid-WRITEBACK → mem_req=0 in the same cycle, cpu_ready=1, counters 0; next read of a prior address misses.
- COUNT_WIDTH=4, 20 read hits → hit_count=15, held.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, FSM state codes and address field helpers for the
// 4-way set-associative cache controller.
package cache_pkg;

    localparam int CACHE_DATA_WIDTH  = 32;
    localparam int CACHE_ADDR_WIDTH  = 16;
    localparam int CACHE_INDEX_WIDTH = 6;
    localparam int CACHE_TAG_WIDTH   = 8;
    localparam int CACHE_NUM_WAYS    = 4;
    localparam int CACHE_COUNT_WIDTH = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_COMPARE   = 2'd1;
    localparam state_t ST_WRITEBACK = 2'd2;
    localparam state_t ST_ALLOCATE  = 2'd3;

    function automatic logic [CACHE_TAG_WIDTH-1:0] tag_of(
        input logic [CACHE_ADDR_WIDTH-1:0] addr
    );
        return addr[CACHE_ADDR_WIDTH-1 -: CACHE_TAG_WIDTH];
    endfunction

    function automatic logic [CACHE_INDEX_WIDTH-1:0] index_of(
        input logic [CACHE_ADDR_WIDTH-1:0] addr
    );
        return addr[2 +: CACHE_INDEX_WIDTH];
    endfunction

    // Word-aligned line address built from a tag and a set index.
    function automatic logic [CACHE_ADDR_WIDTH-1:0] line_addr(
        input logic [CACHE_TAG_WIDTH-1:0]   tag,
        input logic [CACHE_INDEX_WIDTH-1:0] index
    );
        return {tag, index, 2'b00};
    endfunction

endpackage

// File: rtl/cache_victim_select.sv
// Combinational NRU helper: picks the replacement way and computes the
// reference vector after a hit.
module cache_victim_select
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = CACHE_NUM_WAYS
) (
    input  logic [NUM_WAYS-1:0] r_valid,
    input  logic [NUM_WAYS-1:0] r_ref,
    input  logic [NUM_WAYS-1:0] hit,
    output logic [NUM_WAYS-1:0] victim,
    output logic [NUM_WAYS-1:0] next_ref
);

    localparam logic [NUM_WAYS-1:0] WAY0 = {{(NUM_WAYS-1){1'b0}}, 1'b1};

    logic [NUM_WAYS-1:0] invalid_s;
    logic [NUM_WAYS-1:0] unref_s;
    logic [NUM_WAYS-1:0] merged_ref_s;

    // Two's-complement trick isolates the lowest set bit.
    function automatic logic [NUM_WAYS-1:0] lowest_one(input logic [NUM_WAYS-1:0] v);
        return v & (~v + WAY0);
    endfunction

    // Victim priority: lowest invalid, then lowest unreferenced, then way 0.
    always_comb begin
        invalid_s    = ~r_valid;
        unref_s      = ~r_ref;
        merged_ref_s = r_ref | hit;
        victim       = (|invalid_s) ? lowest_one(invalid_s)
                     : (|unref_s)   ? lowest_one(unref_s)
                     :                WAY0;
        next_ref     = (&merged_ref_s) ? hit : merged_ref_s;
    end

endmodule

// File: rtl/cache_controller.sv
// Write-back, write-allocate controller for a 4-way set-associative cache:
// tag compare, NRU replacement, dirty writeback and line refill.
module cache_controller
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH  = CACHE_DATA_WIDTH,
    parameter int ADDR_WIDTH  = CACHE_ADDR_WIDTH,
    parameter int INDEX_WIDTH = CACHE_INDEX_WIDTH,
    parameter int TAG_WIDTH   = CACHE_TAG_WIDTH,
    parameter int NUM_WAYS    = CACHE_NUM_WAYS,
    parameter int COUNT_WIDTH = CACHE_COUNT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpu_req,
    input  logic                            cpu_we,
    input  logic [ADDR_WIDTH-1:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0]           cpu_wdata,
    output logic                            cpu_ready,
    output logic                            cpu_resp_valid,
    output logic [DATA_WIDTH-1:0]           cpu_rdata,
    output logic [INDEX_WIDTH-1:0]          index,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0]   r_tags,
    input  logic [NUM_WAYS*DATA_WIDTH-1:0]  r_data,
    input  logic [NUM_WAYS-1:0]             r_valid,
    input  logic [NUM_WAYS-1:0]             r_dirty,
    input  logic [NUM_WAYS-1:0]             r_ref,
    output logic                            wr_en,
    output logic [NUM_WAYS-1:0]             way_sel,
    output logic [TAG_WIDTH-1:0]            w_tag,
    output logic [DATA_WIDTH-1:0]           w_data,
    output logic                            w_valid,
    output logic                            w_dirty,
    output logic                            update_ref,
    output logic [NUM_WAYS-1:0]             w_ref,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic                            mem_ack,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    output logic [COUNT_WIDTH-1:0]          hit_count,
    output logic [COUNT_WIDTH-1:0]          miss_count
);

    localparam logic [NUM_WAYS-1:0]    WAY0      = {{(NUM_WAYS-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   req_addr_r;
    logic                    req_we_r;
    logic [DATA_WIDTH-1:0]   req_wdata_r;
    logic                    refill_r;
    logic [NUM_WAYS-1:0]     victim_way_r;
    logic [TAG_WIDTH-1:0]    victim_tag_r;
    logic [DATA_WIDTH-1:0]   victim_data_r;
    logic [COUNT_WIDTH-1:0]  hit_count_r;
    logic [COUNT_WIDTH-1:0]  miss_count_r;

    logic [TAG_WIDTH-1:0]    req_tag_s;
    logic [INDEX_WIDTH-1:0]  req_index_s;
    logic [NUM_WAYS-1:0]     hit_raw_s;
    logic [NUM_WAYS-1:0]     hit_way_s;
    logic                    hit_s;
    logic [DATA_WIDTH-1:0]   hit_data_s;
    logic [NUM_WAYS-1:0]     victim_s;
    logic [NUM_WAYS-1:0]     next_ref_s;
    logic [TAG_WIDTH-1:0]    victim_tag_s;
    logic [DATA_WIDTH-1:0]   victim_data_s;
    logic                    victim_dirty_s;
    logic                    unused_offset_s;

    assign req_tag_s       = tag_of(req_addr_r);
    assign req_index_s     = index_of(req_addr_r);
    assign unused_offset_s = ^req_addr_r[1:0];
    assign index           = req_index_s;
    assign hit_count       = hit_count_r;
    assign miss_count      = miss_count_r;

    cache_victim_select #(
        .NUM_WAYS (NUM_WAYS)
    ) u_victim_select (
        .r_valid  (r_valid),
        .r_ref    (r_ref),
        .hit      (hit_way_s),
        .victim   (victim_s),
        .next_ref (next_ref_s)
    );

    // Tag compare plus AND-OR muxing of the hit line and the victim line.
    always_comb begin
        hit_raw_s      = {NUM_WAYS{1'b0}};
        hit_data_s     = {DATA_WIDTH{1'b0}};
        victim_tag_s   = {TAG_WIDTH{1'b0}};
        victim_data_s  = {DATA_WIDTH{1'b0}};
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_raw_s[w] = r_valid[w] && (r_tags[w*TAG_WIDTH +: TAG_WIDTH] == req_tag_s);
        end
        hit_way_s = hit_raw_s & (~hit_raw_s + WAY0);
        hit_s     = |hit_raw_s;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_data_s    = hit_data_s    | ({DATA_WIDTH{hit_way_s[w]}} & r_data[w*DATA_WIDTH +: DATA_WIDTH]);
            victim_tag_s  = victim_tag_s  | ({TAG_WIDTH{victim_s[w]}}   & r_tags[w*TAG_WIDTH +: TAG_WIDTH]);
            victim_data_s = victim_data_s | ({DATA_WIDTH{victim_s[w]}}  & r_data[w*DATA_WIDTH +: DATA_WIDTH]);
        end
        victim_dirty_s = |(victim_s & r_valid & r_dirty);
    end

    // Per-state drive of the CPU, array and memory interfaces.
    always_comb begin
        cpu_ready      = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_rdata      = {DATA_WIDTH{1'b0}};
        wr_en          = 1'b0;
        way_sel        = {NUM_WAYS{1'b0}};
        w_tag          = {TAG_WIDTH{1'b0}};
        w_data         = {DATA_WIDTH{1'b0}};
        w_valid        = 1'b0;
        w_dirty        = 1'b0;
        update_ref     = 1'b0;
        w_ref          = {NUM_WAYS{1'b0}};
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = {ADDR_WIDTH{1'b0}};
        mem_wdata      = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                cpu_ready = 1'b1;
            end
            ST_COMPARE: begin
                if (hit_s) begin
                    cpu_resp_valid = 1'b1;
                    update_ref     = 1'b1;
                    w_ref          = next_ref_s;
                    if (req_we_r) begin
                        wr_en   = 1'b1;
                        way_sel = hit_way_s;
                        w_tag   = req_tag_s;
                        w_data  = req_wdata_r;
                        w_valid = 1'b1;
                        w_dirty = 1'b1;
                    end else begin
                        cpu_rdata = hit_data_s;
                    end
                end else begin
                    cpu_resp_valid = 1'b0;
                end
            end
            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = line_addr(victim_tag_r, req_index_s);
                mem_wdata = victim_data_r;
            end
            ST_ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = line_addr(req_tag_s, req_index_s);
                if (mem_ack) begin
                    wr_en   = 1'b1;
                    way_sel = victim_way_r;
                    w_tag   = req_tag_s;
                    w_data  = mem_rdata;
                    w_valid = 1'b1;
                end else begin
                    wr_en = 1'b0;
                end
            end
            default: begin
                cpu_ready = 1'b0;
            end
        endcase
    end

    // FSM sequencing, request latch and victim capture on a miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            req_addr_r    <= {ADDR_WIDTH{1'b0}};
            req_we_r      <= 1'b0;
            req_wdata_r   <= {DATA_WIDTH{1'b0}};
            refill_r      <= 1'b0;
            victim_way_r  <= {NUM_WAYS{1'b0}};
            victim_tag_r  <= {TAG_WIDTH{1'b0}};
            victim_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cpu_req) begin
                        req_addr_r  <= cpu_addr;
                        req_we_r    <= cpu_we;
                        req_wdata_r <= cpu_wdata;
                        refill_r    <= 1'b0;
                        state_r     <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (hit_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        victim_way_r  <= victim_s;
                        victim_tag_r  <= victim_tag_s;
                        victim_data_r <= victim_data_s;
                        state_r       <= victim_dirty_s ? ST_WRITEBACK : ST_ALLOCATE;
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack) begin
                        state_r <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ack) begin
                        refill_r <= 1'b1;
                        state_r  <= ST_COMPARE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating statistics; the re-compare after a refill is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_r  <= {COUNT_WIDTH{1'b0}};
            miss_count_r <= {COUNT_WIDTH{1'b0}};
        end else if ((state_r == ST_COMPARE) && !refill_r) begin
            if (hit_s) begin
                if (hit_count_r != COUNT_MAX) begin
                    hit_count_r <= hit_count_r + COUNT_ONE;
                end
            end else begin
                if (miss_count_r != COUNT_MAX) begin
                    miss_count_r <= miss_count_r + COUNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: array and memory models around two controller
// instances (default and 4-bit counters) plus a behavioural cache model.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready, cpu_resp_valid;
    logic [31:0] cpu_rdata;
    logic [5:0]  index;
    logic [31:0] r_tags;
    logic [127:0] r_data;
    logic [3:0]  r_valid, r_dirty, r_ref;
    logic        wr_en, w_valid, w_dirty, update_ref;
    logic [3:0]  way_sel, w_ref;
    logic [7:0]  w_tag;
    logic [31:0] w_data;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] hit_count, miss_count;

    logic        d4_ready, d4_resp_valid, d4_wr_en, d4_w_valid, d4_w_dirty, d4_update_ref;
    logic        d4_mem_req, d4_mem_we;
    logic [31:0] d4_rdata, d4_w_data, d4_mem_wdata;
    logic [5:0]  d4_index;
    logic [3:0]  d4_way_sel, d4_w_ref;
    logic [7:0]  d4_w_tag;
    logic [15:0] d4_mem_addr;
    logic [3:0]  d4_hit_count, d4_miss_count;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid),
        .cpu_rdata(cpu_rdata), .index(index), .r_tags(r_tags), .r_data(r_data),
        .r_valid(r_valid), .r_dirty(r_dirty), .r_ref(r_ref), .wr_en(wr_en), .way_sel(way_sel),
        .w_tag(w_tag), .w_data(w_data), .w_valid(w_valid), .w_dirty(w_dirty),
        .update_ref(update_ref), .w_ref(w_ref), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // Same stimulus and array view; only the counter width differs.
    cache_controller #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(d4_ready), .cpu_resp_valid(d4_resp_valid),
        .cpu_rdata(d4_rdata), .index(d4_index), .r_tags(r_tags), .r_data(r_data),
        .r_valid(r_valid), .r_dirty(r_dirty), .r_ref(r_ref), .wr_en(d4_wr_en), .way_sel(d4_way_sel),
        .w_tag(d4_w_tag), .w_data(d4_w_data), .w_valid(d4_w_valid), .w_dirty(d4_w_dirty),
        .update_ref(d4_update_ref), .w_ref(d4_w_ref), .mem_req(d4_mem_req), .mem_we(d4_mem_we),
        .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(d4_hit_count), .miss_count(d4_miss_count)
    );

    // Storage array: combinational read, write on clock edge, cleared by rst.
    logic [7:0]  a_tag  [0:63][0:3];
    logic [31:0] a_data [0:63][0:3];
    logic [3:0]  a_valid [0:63];
    logic [3:0]  a_dirty [0:63];
    logic [3:0]  a_ref   [0:63];

    always_comb begin
        r_tags  = 32'h0;
        r_data  = 128'h0;
        for (int w = 0; w < 4; w++) begin
            r_tags[w*8 +: 8]   = a_tag[index][w];
            r_data[w*32 +: 32] = a_data[index][w];
        end
        r_valid = a_valid[index];
        r_dirty = a_dirty[index];
        r_ref   = a_ref[index];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 64; s++) begin
                a_valid[s] <= 4'b0000;
                a_dirty[s] <= 4'b0000;
                a_ref[s]   <= 4'b0000;
            end
        end else begin
            for (int w = 0; w < 4; w++) begin
                if (wr_en && way_sel[w]) begin
                    a_tag[index][w]   <= w_tag;
                    a_data[index][w]  <= w_data;
                    a_valid[index][w] <= w_valid;
                    a_dirty[index][w] <= w_dirty;
                end
            end
            if (update_ref) a_ref[index] <= w_ref;
        end
    end

    // Main memory and the CPU-visible golden memory.
    logic [31:0] mainmem [int];
    logic [31:0] gold    [int];

    function automatic logic [31:0] mem_init(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        return mainmem.exists(int'(a)) ? mainmem[int'(a)] : mem_init(a);
    endfunction

    function automatic logic [31:0] gold_rd(input logic [15:0] a);
        return gold.exists(int'(a)) ? gold[int'(a)] : mem_init(a);
    endfunction

    // Behavioural cache residency model.
    bit         m_valid [0:63][0:3];
    bit         m_dirty [0:63][0:3];
    bit         m_ref   [0:63][0:3];
    logic [7:0] m_tag   [0:63][0:3];
    int         model_hits, model_misses;
    int         checks, failures;
    logic [15:0] last_wb_addr, last_fetch_addr;
    logic [31:0] last_wb_data;

    function automatic void touch(input int s, input int w);
        m_ref[s][w] = 1'b1;
        if (m_ref[s][0] && m_ref[s][1] && m_ref[s][2] && m_ref[s][3]) begin
            for (int k = 0; k < 4; k++) m_ref[s][k] = 1'b0;
            m_ref[s][w] = 1'b1;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_ref[s][w]   = 1'b0;
                m_tag[s][w]   = 8'h00;
            end
        model_hits   = 0;
        model_misses = 0;
        gold.delete();
        foreach (mainmem[k]) gold[k] = mainmem[k];
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters();
        chk("hit_count", hit_count, model_hits);
        chk("miss_count", miss_count, model_misses);
        chk("hit_count_w4", d4_hit_count, (model_hits > 15) ? 15 : model_hits);
        chk("miss_count_w4", d4_miss_count, (model_misses > 15) ? 15 : model_misses);
    endtask

    // One CPU access: predict from the model, then drive and serve memory.
    task automatic access(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                          input int delay, input bit stray);
        int s, hw, v, wait_cnt, ack_cyc;
        bit exp_hit, exp_wb, wb_seen, fetch_seen, done;
        logic [15:0] line, wb_addr;
        logic [31:0] exp_rd, wb_data;
        logic [7:0]  tg;
        line = {addr[15:2], 2'b00};
        s    = int'(addr[7:2]);
        tg   = addr[15:8];
        hw   = -1;
        for (int w = 0; w < 4; w++)
            if (hw < 0 && m_valid[s][w] && m_tag[s][w] == tg) hw = w;
        exp_hit = (hw >= 0);
        exp_wb  = 1'b0;
        wb_addr = 16'h0;
        wb_data = 32'h0;
        if (exp_hit) begin
            model_hits++;
        end else begin
            model_misses++;
            v = -1;
            for (int w = 0; w < 4; w++) if (v < 0 && !m_valid[s][w]) v = w;
            for (int w = 0; w < 4; w++) if (v < 0 && !m_ref[s][w]) v = w;
            if (v < 0) v = 0;
            if (m_valid[s][v] && m_dirty[s][v]) begin
                exp_wb  = 1'b1;
                wb_addr = {m_tag[s][v], addr[7:2], 2'b00};
                wb_data = gold_rd(wb_addr);
            end
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            m_tag[s][v]   = tg;
            hw = v;
        end
        touch(s, hw);
        if (we) m_dirty[s][hw] = 1'b1;
        exp_rd = gold_rd(line);
        if (we) gold[int'(line)] = wdata;

        chk("ready_before_req", cpu_ready, 1);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        wait_cnt = 0; ack_cyc = -10; done = 0; wb_seen = 0; fetch_seen = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (cpu_resp_valid) begin
                done = 1;
                if (!we) chk("read_data", cpu_rdata, exp_rd);
                else     chk("write_resp_rdata", cpu_rdata, 0);
                chk("fetch_taken", fetch_seen, !exp_hit);
                chk("writeback_taken", wb_seen, exp_wb);
                if (exp_hit) chk("hit_latency", cyc, 0);
                else         chk("refill_latency", cyc, ack_cyc + 1);
            end else if (mem_req) begin
                chk("ready_low_busy", cpu_ready, 0);
                if (mem_we) begin
                    wb_seen = 1;
                    chk("wb_addr", mem_addr, wb_addr);
                    chk("wb_data", mem_wdata, wb_data);
                    last_wb_addr = mem_addr;
                    last_wb_data = mem_wdata;
                end else begin
                    fetch_seen = 1;
                    chk("fetch_addr", mem_addr, line);
                    last_fetch_addr = mem_addr;
                end
                if (stray && !mem_we && wait_cnt == 2) begin
                    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h9234; cpu_wdata = 32'h0BAD0BAD;
                end
                if (wait_cnt >= delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) mainmem[int'(mem_addr)] = mem_wdata;
                    else        mem_rdata = mem_rd(mem_addr);
                    wait_cnt = 0;
                    ack_cyc  = cyc;
                end else begin
                    wait_cnt++;
                end
            end
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            cpu_req   = 1'b0;
            mem_rdata = $urandom;
        end
        chk("access_completed", done, 1);
        check_counters();
    endtask

    initial begin
        bit found;
        checks = 0; failures = 0;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        model_clear();
        #3;
        chk("rst_cpu_ready", cpu_ready, 1);
        chk("rst_resp_valid", cpu_resp_valid, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_update_ref", update_ref, 0);
        chk("rst_index", index, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold miss then repeat hit.
        mainmem[16'h1234] = 32'hDEADBEEF;
        gold[16'h1234]    = 32'hDEADBEEF;
        access(1'b0, 16'h1234, 32'h0, 2, 1'b0);
        chk("cold_fetch_addr", last_fetch_addr, 16'h1234);
        chk("cold_miss_count", miss_count, 1);
        chk("cold_hit_count", hit_count, 0);
        access(1'b0, 16'h1234, 32'h0, 0, 1'b0);
        chk("repeat_hit_count", hit_count, 1);

        // NRU eviction of a dirty line.
        do_reset();
        access(1'b1, 16'h1234, 32'hA5A5A5A5, 1, 1'b0);
        chk("ref_after_1", a_ref[13], 4'b0001);
        access(1'b0, 16'h2234, 32'h0, 0, 1'b0);
        chk("ref_after_2", a_ref[13], 4'b0011);
        access(1'b0, 16'h3234, 32'h0, 0, 1'b0);
        chk("ref_after_3", a_ref[13], 4'b0111);
        access(1'b0, 16'h4234, 32'h0, 0, 1'b0);
        chk("ref_after_4", a_ref[13], 4'b1000);
        access(1'b0, 16'h5234, 32'h0, 1, 1'b0);
        chk("evict_wb_addr", last_wb_addr, 16'h1234);
        chk("evict_wb_data", last_wb_data, 32'hA5A5A5A5);
        chk("evict_fetch_addr", last_fetch_addr, 16'h5234);

        // Long refill stall with a stray request pulse that must be dropped.
        access(1'b0, 16'h6234, 32'h0, 5, 1'b1);
        chk("stray_dropped_ready", cpu_ready, 1);
        chk("stray_dropped_resp", cpu_resp_valid, 0);
        access(1'b0, 16'h9234, 32'h0, 0, 1'b0);

        // Reset in the middle of a writeback.
        do_reset();
        access(1'b1, 16'h1234, 32'h11111111, 0, 1'b0);
        access(1'b1, 16'h2234, 32'h22222222, 0, 1'b0);
        access(1'b1, 16'h3234, 32'h33333333, 0, 1'b0);
        access(1'b1, 16'h4234, 32'h44444444, 0, 1'b0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5234;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (mem_req && mem_we) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("wb_reached", found, 1);
        rst = 1'b1;
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_cpu_ready", cpu_ready, 1);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_hit_count", hit_count, 0);
        chk("abort_miss_count", miss_count, 0);
        do_reset();
        access(1'b0, 16'h1234, 32'h0, 0, 1'b0);
        chk("post_abort_miss", miss_count, 1);

        // 4-bit counter saturation.
        do_reset();
        access(1'b0, 16'h1234, 32'h0, 0, 1'b0);
        for (int i = 0; i < 20; i++) access(1'b0, 16'h1234, 32'h0, 0, 1'b0);
        chk("sat_hit_w4", d4_hit_count, 4'hF);
        chk("sat_hit_w16", hit_count, 20);

        // Randomized traffic over a few conflicting sets.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [5:0]  idx;
            logic [15:0] a;
            case ($urandom_range(0, 2))
                0:       idx = 6'd0;
                1:       idx = 6'd13;
                default: idx = 6'd63;
            endcase
            a = {8'($urandom_range(1, 7)), idx, 2'($urandom_range(0, 3))};
            access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
